// File: rtl/imem_load_ctrl_pkg.sv
// rtl/imem_load_ctrl_pkg.sv - shared state encodings and constants for the IMem loader
package imem_load_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_REL,
        ST_RUN,
        ST_ERR
    } state_t;

    // Bytes in the length header and in each packed instruction word
    localparam int LEN_BYTES   = 4;
    localparam int BYTE_CNT_W  = $clog2(LEN_BYTES);
    localparam int IMEM_ADDR_W = 13;

endpackage

// File: rtl/imem_load_ctrl_byte_packer.sv
// rtl/imem_load_ctrl_byte_packer.sv - 8-to-32 little-endian word assembler
module byte_packer
    import imem_load_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [BYTE_CNT_W-1:0] byte_cnt;

    // Drop each byte into its lane; word_valid pulses the cycle after the fourth byte
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_cnt   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && (byte_cnt == BYTE_CNT_W'(LEN_BYTES - 1));
            if (byte_valid) begin
                word_data[8*byte_cnt +: 8] <= byte_data;
                byte_cnt                   <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - boot loader that fills IMem from a byte stream and releases the core
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              run_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              core_reset,
    output logic              load_busy,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    // Largest legal word count; the header is compared at full 32-bit width
    localparam logic [31:0] MAX_WORDS = 32'(2 ** ADDR_W);

    state_t           state;
    logic [ADDR_W:0]  len_q;
    logic [ADDR_W:0]  words_q;
    logic [CNT_W-1:0] to_cnt;
    logic             word_valid;
    logic [31:0]      word_data;
    logic             rx_fire;
    logic             start_load;
    logic             in_load;
    logic             timeout_hit;
    logic             last_write;

    assign in_load     = (state == ST_LEN) || (state == ST_DATA);
    assign rx_ready    = in_load;
    assign rx_fire     = rx_valid && rx_ready;
    assign start_load  = load_start &&
                         ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERR));
    assign timeout_hit = (TIMEOUT_CYC != 0) && in_load && !rx_fire &&
                         (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // The length header goes through the same packer but is never written to IMem
    assign imem_we      = word_valid && (state == ST_DATA);
    assign imem_waddr   = words_q[ADDR_W-1:0];
    assign imem_wdata   = word_data;
    assign words_loaded = words_q;
    assign last_write   = imem_we && ((words_q + 1'b1) == len_q);

    assign core_hold  = (state != ST_RUN);
    assign core_reset = (state == ST_REL);
    assign load_busy  = in_load;
    assign load_err   = (state == ST_ERR);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_load),
        .byte_valid (rx_fire),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // Load FSM with idle-timeout and word-address bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            words_q <= '0;
            to_cnt  <= '0;
        end else begin
            if (start_load || rx_fire) begin
                to_cnt <= '0;
            end else if (in_load && (TIMEOUT_CYC != 0)) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (start_load) begin
                words_q <= '0;
            end else if (imem_we) begin
                words_q <= words_q + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state <= ST_LEN;
                    end else if (run_req) begin
                        state <= ST_REL;
                    end
                end
                ST_LEN: begin
                    if (word_valid) begin
                        if (word_data == 32'd0) begin
                            state <= ST_REL;
                        end else if (word_data > MAX_WORDS) begin
                            state <= ST_ERR;
                        end else begin
                            len_q <= word_data[ADDR_W:0];
                            state <= ST_DATA;
                        end
                    end else if (timeout_hit) begin
                        state <= ST_ERR;
                    end
                end
                ST_DATA: begin
                    // A final write coinciding with the timeout still completes the load
                    if (last_write) begin
                        state <= ST_REL;
                    end else if (timeout_hit) begin
                        state <= ST_ERR;
                    end
                end
                ST_REL: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (load_start) begin
                        state <= ST_LEN;
                    end
                end
                ST_ERR: begin
                    if (load_start) begin
                        state <= ST_LEN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - scoreboard bench for imem_load_ctrl
module tb_imem_load_ctrl;

    localparam int ADDR_W = 13;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_start = 1'b0;
    logic              run_req = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              core_reset;
    logic              load_busy;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    int   n_cmp = 0;
    int   n_fail = 0;
    wr_t  sb[$];
    logic [7:0] bq[$];

    imem_load_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(16), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .run_req      (run_req),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .core_reset   (core_reset),
        .load_busy    (load_busy),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            tick();
            n++;
        end
        if (!rx_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_ready_wait: got 0 expected 1 within 20 cycles");
        end
        tick();
    endtask

    task automatic send_bq(input int gap);
        foreach (bq[i]) begin
            send_byte(bq[i]);
            if (gap > 0 && i != bq.size() - 1) begin
                rx_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_run();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
    endtask

    // Write monitor: every IMem write must match the oldest expected write
    always @(negedge clk) begin
        if (imem_we) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         imem_waddr, imem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("waddr", 64'(imem_waddr), 64'(e.addr));
                check("wdata", 64'(imem_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_core_hold", 64'(core_hold), 64'd1);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_core_reset", 64'(core_reset), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        check("rst_busy_err", 64'({load_busy, load_err}), 64'd0);
        reset = 1'b0;
        tick();
        check("idle_hold", 64'({core_hold, core_reset}), 64'b10);

        // Release without loading
        pulse_run();
        check("run_rel_pulse", 64'({core_reset, core_hold}), 64'b11);
        tick();
        check("run_released", 64'({core_reset, core_hold}), 64'b00);

        // Two-word load, back to back
        pulse_start();
        check("len_entry", 64'({core_hold, load_busy, rx_ready}), 64'b111);
        sb.push_back('{13'd0, 32'h00500013});
        sb.push_back('{13'd1, 32'h00A00093});
        bq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
               8'h93, 8'h00, 8'hA0, 8'h00};
        send_bq(0);
        tick();
        check("load2_rel", 64'({core_reset, core_hold}), 64'b11);
        check("load2_words", 64'(words_loaded), 64'd2);
        check("load2_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        check("load2_run", 64'({core_reset, core_hold}), 64'b00);

        // Zero-length header releases immediately
        pulse_start();
        bq = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_bq(0);
        tick();
        check("len0_rel", 64'(core_reset), 64'd1);
        check("len0_words", 64'(words_loaded), 64'd0);
        tick();
        check("len0_run", 64'(core_hold), 64'd0);

        // Header one past capacity
        pulse_start();
        bq = '{8'h01, 8'h20, 8'h00, 8'h00};
        send_bq(0);
        tick();
        check("len2001_err", 64'({load_err, core_hold, rx_ready}), 64'b110);

        // Huge header must not be truncated to a small count
        pulse_start();
        bq = '{8'h01, 8'h00, 8'h00, 8'h80};
        send_bq(0);
        tick();
        check("len_big_err", 64'(load_err), 64'd1);
        pulse_run();
        check("err_run_ignored", 64'({load_err, core_reset}), 64'b10);

        // Timeout after two data bytes
        pulse_start();
        bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        send_bq(0);
        repeat (15) tick();
        check("to_not_yet", 64'({load_err, load_busy}), 64'b01);
        tick();
        check("to_err", 64'({load_err, load_busy}), 64'b10);

        // Recovery load with gaps on rx_valid
        pulse_start();
        sb.push_back('{13'd0, 32'hDEADBEEF});
        bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_bq(2);
        tick();
        check("recover_rel", 64'({core_reset, load_err}), 64'b10);
        check("recover_words", 64'(words_loaded), 64'd1);
        tick();
        check("recover_run", 64'(core_hold), 64'd0);

        // Full-capacity header, load_start ignored in DATA, then reset mid-load
        pulse_start();
        sb.push_back('{13'd0, 32'h11223344});
        sb.push_back('{13'd1, 32'h88776655});
        bq = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55, 8'h66};
        send_bq(0);
        check("max_words_mid", 64'({load_busy, words_loaded}), 64'({1'b1, 14'd1}));
        pulse_start();
        check("data_start_ignored", 64'({load_busy, words_loaded}), 64'({1'b1, 14'd1}));
        bq = '{8'h77, 8'h88};
        send_bq(0);
        reset = 1'b1;
        tick();
        check("mid_rst_state", 64'({load_busy, imem_we, core_hold, rx_ready, core_reset}),
              64'b00100);
        check("mid_rst_words", 64'(words_loaded), 64'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("post_rst_idle", 64'({core_hold, core_reset, load_err}), 64'b100);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
